muldiv_unit: RTL

Iterative RV32M multiply/divide unit for the EX stage of the pipelined core, parametrised in operand width.
- Accepts one operation at a time through a start/busy/done handshake.
- Runs a radix-2 shift-add multiplier or a restoring divider for XLEN cycles.
- Returns the result and destination register tag for writeback.
- Handles divide-by-zero and signed overflow on a single-cycle fast path.
- The hazard unit stalls F/D/E on o_busy and flushes via i_kill.

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative
// multiply/divide unit. The EX stage is the master, the unit is the slave.
interface muldiv_unit_if #(
   parameter int XLEN = 32,
   parameter int TAGW = 5
);
   logic            i_start;
   logic [2:0]      i_op;
   logic [XLEN-1:0] i_a;
   logic [XLEN-1:0] i_b;
   logic [TAGW-1:0] i_rd;
   logic            i_kill;
   logic            o_busy;
   logic            o_done;
   logic [XLEN-1:0] o_result;
   logic [TAGW-1:0] o_rd;

   modport master (
      output i_start, i_op, i_a, i_b, i_rd, i_kill,
      input  o_busy, o_done, o_result, o_rd
   );

   modport slave (
      input  i_start, i_op, i_a, i_b, i_rd, i_kill,
      output o_busy, o_done, o_result, o_rd
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider on operand magnitudes, one bit per cycle, with a
// single-cycle path for divide-by-zero and signed-overflow cases.
module muldiv_unit #(
   parameter int XLEN = 32,
   parameter int TAGW = 5
) (
   input  logic        clk,
   input  logic        reset,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [2:0]        op_q;
   logic [TAGW-1:0]   rd_q;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   opnd;     // multiplicand (mul) or divisor (div) magnitude
   logic [2*XLEN-1:0] acc;      // {hi, lo}: product, or {remainder, quotient}
   logic [CW-1:0]     cnt;
   logic              busy_q;
   logic              done_q;
   logic [XLEN-1:0]   result_q;
   logic [TAGW-1:0]   rd_out_q;

   logic              is_div, a_signed, b_signed, in_a_neg, in_b_neg;
   logic [XLEN-1:0]   mag_a, mag_b, fast_res;
   logic              div_zero, div_ovf, accept;
   logic [XLEN:0]     mul_sum, div_hi, div_diff;
   logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod;
   logic [XLEN-1:0]   quot, rem, final_res;

   // Decode signedness, magnitudes and fast-path cases of the incoming request
   always_comb begin
      // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
      is_div   = bus.i_op[2];
      a_signed = is_div ? ~bus.i_op[0] : (bus.i_op[1:0] != 2'b11);
      b_signed = is_div ? ~bus.i_op[0] : ~bus.i_op[1];
      in_a_neg = a_signed & bus.i_a[XLEN-1];
      in_b_neg = b_signed & bus.i_b[XLEN-1];
      mag_a    = in_a_neg ? -bus.i_a : bus.i_a;
      mag_b    = in_b_neg ? -bus.i_b : bus.i_b;
      div_zero = is_div & (bus.i_b == '0);
      div_ovf  = is_div & ~bus.i_op[0] & (bus.i_a == MIN_NEG) & (bus.i_b == '1);
      if (div_zero) fast_res = bus.i_op[1] ? bus.i_a : '1;
      else          fast_res = bus.i_op[1] ? '0 : bus.i_a;
      accept   = bus.i_start & ~bus.i_kill & (state != RUN);
   end

   // One iteration of shift-add / restoring divide, plus sign fix-up of the final value
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : '0)};
      mul_next = {mul_sum, acc[XLEN-1:1]};
      div_hi   = acc[2*XLEN-1:XLEN-1];
      div_diff = div_hi - {1'b0, opnd};
      if (div_diff[XLEN]) div_next = {div_hi[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else                div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      acc_next = op_q[2] ? div_next : mul_next;
      prod     = (a_neg ^ b_neg) ? -acc_next : acc_next;
      quot     = (a_neg ^ b_neg) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
      rem      = a_neg ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
      case (op_q)
         3'b000:                 final_res = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         final_res = quot;
         default:                final_res = rem;
      endcase
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state    <= IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         a_neg    <= 1'b0;
         b_neg    <= 1'b0;
         opnd     <= '0;
         acc      <= '0;
         cnt      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
      end else if (bus.i_kill) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(XLEN-1)) begin
                  state    <= DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= final_res;
                  rd_out_q <= rd_q;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
               if (accept) begin
                  op_q  <= bus.i_op;
                  rd_q  <= bus.i_rd;
                  a_neg <= in_a_neg;
                  b_neg <= in_b_neg;
                  cnt   <= '0;
                  if (div_zero || div_ovf) begin
                     state    <= DONE;
                     done_q   <= 1'b1;
                     result_q <= fast_res;
                     rd_out_q <= bus.i_rd;
                  end else begin
                     state  <= RUN;
                     busy_q <= 1'b1;
                     opnd   <= is_div ? mag_b : mag_a;
                     acc    <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                  end
               end
            end
         endcase
      end
   end

   assign bus.o_busy   = busy_q;
   assign bus.o_done   = done_q;
   assign bus.o_result = result_q;
   assign bus.o_rd     = rd_out_q;
endmodule
